// File: rtl/color_seq_decoder.sv
// Decodes a 2-3-4-5 color code stream into 4:4:4 RGB and tracks lock onto the
// repeating sequence, flagging a sticky error when a locked stream breaks.
module color_seq_decoder #(
  parameter int CYCLE_W     = 8,
  parameter int LOCK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         color_in,
  input  logic               color_valid,
  input  logic               clear_err,
  output logic [11:0]        rgb,
  output logic               rgb_valid,
  output logic               seq_locked,
  output logic               seq_error,
  output logic [CYCLE_W-1:0] cycle_count
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  state_t             state, state_next;
  logic [3:0]         expected, expected_next;
  logic [3:0]         lock_cnt, lock_cnt_next;
  logic [CYCLE_W-1:0] cycle_count_next;
  logic               seq_error_next;
  logic               err_set;
  logic [11:0]        palette;

  always_comb begin
    case (color_in)
      4'd2:    palette = 12'hF00;
      4'd3:    palette = 12'h0F0;
      4'd4:    palette = 12'h00F;
      4'd5:    palette = 12'hFFF;
      default: palette = 12'h000;
    endcase
  end

  // Any mismatch restarts tracking: a 2 is itself a valid sequence start,
  // anything else drops back to hunting. Only a broken lock is an error.
  always_comb begin
    state_next       = state;
    expected_next    = expected;
    lock_cnt_next    = lock_cnt;
    cycle_count_next = cycle_count;
    err_set          = 1'b0;
    if (color_valid) begin
      case (state)
        HUNT: begin
          if (color_in == 4'd2) begin
            state_next    = TRACK;
            expected_next = 4'd3;
          end
        end
        default: begin
          if (color_in == expected) begin
            expected_next = (expected == 4'd5) ? 4'd2 : expected + 4'd1;
            if (expected == 4'd5) begin
              if (cycle_count != '1)
                cycle_count_next = cycle_count + CYCLE_W'(1);
              if (lock_cnt < 4'(LOCK_CYCLES))
                lock_cnt_next = lock_cnt + 4'd1;
              if (state == TRACK && lock_cnt_next == 4'(LOCK_CYCLES))
                state_next = LOCKED;
            end
          end else begin
            err_set          = (state == LOCKED);
            expected_next    = 4'd3;
            lock_cnt_next    = 4'd0;
            cycle_count_next = '0;
            state_next       = (color_in == 4'd2) ? TRACK : HUNT;
          end
        end
      endcase
    end
    seq_error_next = err_set | (seq_error & ~clear_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      expected    <= 4'd3;
      lock_cnt    <= 4'd0;
      cycle_count <= '0;
      seq_error   <= 1'b0;
      rgb         <= 12'h000;
      rgb_valid   <= 1'b0;
    end else begin
      state       <= state_next;
      expected    <= expected_next;
      lock_cnt    <= lock_cnt_next;
      cycle_count <= cycle_count_next;
      seq_error   <= seq_error_next;
      rgb_valid   <= color_valid;
      if (color_valid)
        rgb <= palette;
    end
  end

  assign seq_locked = (state == LOCKED);

endmodule

// File: tb/tb_color_seq_decoder.sv
// Directed-vector bench for color_seq_decoder: stimulus pushes expected
// responses, a negedge monitor pops and compares whenever rgb_valid is high.
module tb_color_seq_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  color_in;
  logic        color_valid;
  logic        clear_err;
  logic [11:0] rgb, rgb2;
  logic        rgb_valid, rgb_valid2;
  logic        seq_locked, seq_locked2;
  logic        seq_error, seq_error2;
  logic [7:0]  cycle_count;
  logic [1:0]  cycle_count2;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] rgb;
    logic        lk;
    logic        er;
    logic [7:0]  cnt;
    logic [1:0]  cnt2;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  color_seq_decoder dut (
    .clk(clk), .reset(reset), .color_in(color_in), .color_valid(color_valid),
    .clear_err(clear_err), .rgb(rgb), .rgb_valid(rgb_valid),
    .seq_locked(seq_locked), .seq_error(seq_error), .cycle_count(cycle_count)
  );

  // Narrow counter copy exercises cycle_count saturation on the same stream.
  color_seq_decoder #(.CYCLE_W(2)) dut2 (
    .clk(clk), .reset(reset), .color_in(color_in), .color_valid(color_valid),
    .clear_err(clear_err), .rgb(rgb2), .rgb_valid(rgb_valid2),
    .seq_locked(seq_locked2), .seq_error(seq_error2), .cycle_count(cycle_count2)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rgb_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_valid: got rgb_valid=1 rgb=%h expected no output at %0t", rgb, $time);
      end else begin
        e = q.pop_front();
        cmp("rgb", 32'(rgb), 32'(e.rgb));
        cmp("seq_locked", 32'(seq_locked), 32'(e.lk));
        cmp("seq_error", 32'(seq_error), 32'(e.er));
        cmp("cycle_count", 32'(cycle_count), 32'(e.cnt));
        cmp("cycle_count_w2", 32'(cycle_count2), 32'(e.cnt2));
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic clr, input logic [3:0] code,
                               input logic [11:0] eRgb, input logic eLk, input logic eEr,
                               input logic [7:0] eCnt, input logic [1:0] eCnt2);
    exp_t e;
    color_valid = v;
    clear_err   = clr;
    color_in    = code;
    if (v) begin
      e.rgb = eRgb; e.lk = eLk; e.er = eEr; e.cnt = eCnt; e.cnt2 = eCnt2;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyCycle(input logic lkS, input logic lkE, input logic er,
                            input logic [7:0] cb, input logic [7:0] ca,
                            input logic [1:0] c2b, input logic [1:0] c2a);
    applyStimulus(1'b1, 1'b0, 4'd2, 12'hF00, lkS, er, cb, c2b);
    applyStimulus(1'b1, 1'b0, 4'd3, 12'h0F0, lkS, er, cb, c2b);
    applyStimulus(1'b1, 1'b0, 4'd4, 12'h00F, lkS, er, cb, c2b);
    applyStimulus(1'b1, 1'b0, 4'd5, 12'hFFF, lkE, er, ca, c2a);
  endtask

  task automatic checkOutput(input string name, input logic [11:0] eRgb, input logic eVal,
                             input logic eLk, input logic eEr, input logic [7:0] eCnt,
                             input logic [1:0] eCnt2);
    cmp({name, ".rgb"}, 32'(rgb), 32'(eRgb));
    cmp({name, ".rgb_valid"}, 32'(rgb_valid), 32'(eVal));
    cmp({name, ".seq_locked"}, 32'(seq_locked), 32'(eLk));
    cmp({name, ".seq_error"}, 32'(seq_error), 32'(eEr));
    cmp({name, ".cycle_count"}, 32'(cycle_count), 32'(eCnt));
    cmp({name, ".cycle_count_w2"}, 32'(cycle_count2), 32'(eCnt2));
  endtask

  initial begin
    // Reset held with valid and clear_err high: reset must dominate.
    reset = 1'b1; color_valid = 1'b1; color_in = 4'd2; clear_err = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("reset", 12'h000, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    reset = 1'b0;

    // Two clean cycles lock the stream.
    applyCycle(1'b0, 1'b0, 1'b0, 8'd0, 8'd1, 2'd0, 2'd1);
    applyCycle(1'b0, 1'b1, 1'b0, 8'd1, 8'd2, 2'd1, 2'd2);

    // Gaps with a bad code on the bus must not disturb anything.
    applyStimulus(1'b0, 1'b0, 4'd7, 12'h000, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b0, 1'b0, 4'd7, 12'h000, 1'b0, 1'b0, 8'd0, 2'd0);
    @(negedge clk);
    checkOutput("gap_hold", 12'hFFF, 1'b0, 1'b1, 1'b0, 8'd2, 2'd2);

    // Locked cycles continue counting; the narrow counter saturates at 3.
    applyCycle(1'b1, 1'b1, 1'b0, 8'd2, 8'd3, 2'd2, 2'd3);
    applyCycle(1'b1, 1'b1, 1'b0, 8'd3, 8'd4, 2'd3, 2'd3);
    applyCycle(1'b1, 1'b1, 1'b0, 8'd4, 8'd5, 2'd3, 2'd3);

    // Locked break with a 4: error, back to HUNT, counters cleared.
    applyStimulus(1'b1, 1'b0, 4'd4, 12'h00F, 1'b0, 1'b1, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd3, 12'h0F0, 1'b0, 1'b1, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b1, 4'd5, 12'hFFF, 1'b0, 1'b0, 8'd0, 2'd0);

    // TRACK mismatches never raise the error; a 2 restarts tracking.
    applyStimulus(1'b1, 1'b0, 4'd2, 12'hF00, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd3, 12'h0F0, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd7, 12'h000, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd2, 12'hF00, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd3, 12'h0F0, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd2, 12'hF00, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd3, 12'h0F0, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd4, 12'h00F, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd5, 12'hFFF, 1'b0, 1'b0, 8'd1, 2'd1);
    applyCycle(1'b0, 1'b1, 1'b0, 8'd1, 8'd2, 2'd1, 2'd2);

    // Invalid code while locked, then relock with the error still sticky.
    applyStimulus(1'b1, 1'b0, 4'd7, 12'h000, 1'b0, 1'b1, 8'd0, 2'd0);
    applyCycle(1'b0, 1'b0, 1'b1, 8'd0, 8'd1, 2'd0, 2'd1);
    applyCycle(1'b0, 1'b1, 1'b1, 8'd1, 8'd2, 2'd1, 2'd2);
    applyStimulus(1'b1, 1'b1, 4'd2, 12'hF00, 1'b1, 1'b0, 8'd2, 2'd2);

    // Clear coincident with a locked mismatch loses; clear alone next cycle wins.
    applyStimulus(1'b1, 1'b1, 4'd2, 12'hF00, 1'b0, 1'b1, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b1, 4'd3, 12'h0F0, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd4, 12'h00F, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd5, 12'hFFF, 1'b0, 1'b0, 8'd1, 2'd1);
    applyStimulus(1'b1, 1'b0, 4'd2, 12'hF00, 1'b0, 1'b0, 8'd1, 2'd1);
    applyStimulus(1'b1, 1'b0, 4'd3, 12'h0F0, 1'b0, 1'b0, 8'd1, 2'd1);

    // Mid-cycle reset with valid high discards TRACK progress.
    color_valid = 1'b1; color_in = 4'd4; clear_err = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("mid_reset", 12'h000, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 4'd4, 12'h00F, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b0, 1'b0, 4'd2, 12'h000, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b0, 1'b0, 4'd2, 12'h000, 1'b0, 1'b0, 8'd0, 2'd0);
    @(negedge clk);
    checkOutput("gap_after_reset", 12'h00F, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd3, 12'h0F0, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd4, 12'h00F, 1'b0, 1'b0, 8'd0, 2'd0);
    applyStimulus(1'b1, 1'b0, 4'd5, 12'hFFF, 1'b0, 1'b0, 8'd0, 2'd0);

    color_valid = 1'b0;
    clear_err   = 1'b0;
    repeat (3) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending responses expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
